// File: rtl/ex_mem_pkg.sv
// Shared types for the EX->MEM stage: head/skid payload, occupancy states,
// load/store access-size codes and the branch-taken helper.
package ex_mem_pkg;

    localparam int EM_DATA_WIDTH     = 32;
    localparam int EM_REG_ADDR_WIDTH = 5;

    localparam logic [2:0] F3_LB = 3'b000;
    localparam logic [2:0] F3_LH = 3'b001;
    localparam logic [2:0] F3_LW = 3'b010;
    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_t;

    typedef struct packed {
        logic [EM_DATA_WIDTH-1:0]     wb_data;
        logic [EM_DATA_WIDTH-1:0]     store_data;
        logic [EM_REG_ADDR_WIDTH-1:0] rd;
        logic                         reg_write;
        logic                         mem_read;
        logic                         mem_write;
        logic [2:0]                   funct3;
    } ex_mem_payload_t;

    // ALU compare ops return 0/1, so bit 0 is the branch condition.
    function automatic logic is_taken(input logic branch, input logic jal,
                                      input logic jalr, input logic cmp_lsb);
        return jal | jalr | (branch & cmp_lsb);
    endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX-side and MEM-side bus of the EX->MEM stage; the stage binds the slave modport.
interface ex_mem_stage_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    // Both sides: a transfer happens on a rising edge where valid & ready are
    // high; valid never depends on ready and the payload is held while stalled.
    logic                      ex_valid;
    logic                      ex_ready;
    logic [DATA_WIDTH-1:0]     ex_alu_result;
    logic [DATA_WIDTH-1:0]     ex_store_data;
    logic [DATA_WIDTH-1:0]     ex_pc_plus4;
    logic [DATA_WIDTH-1:0]     ex_pc_imm;
    logic [REG_ADDR_WIDTH-1:0] ex_rd;
    logic                      ex_reg_write;
    logic                      ex_mem_read;
    logic                      ex_mem_write;
    logic                      ex_branch;
    logic                      ex_jal;
    logic                      ex_jalr;
    logic [2:0]                ex_funct3;

    logic                      mem_valid;
    logic                      mem_ready;
    logic [DATA_WIDTH-1:0]     mem_wb_data;
    logic [DATA_WIDTH-1:0]     mem_store_data;
    logic [REG_ADDR_WIDTH-1:0] mem_rd;
    logic                      mem_reg_write;
    logic                      mem_mem_read;
    logic                      mem_mem_write;
    logic [2:0]                mem_funct3;

    modport master (
        output ex_valid, ex_alu_result, ex_store_data, ex_pc_plus4, ex_pc_imm,
               ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
               ex_jal, ex_jalr, ex_funct3, mem_ready,
        input  ex_ready, mem_valid, mem_wb_data, mem_store_data, mem_rd,
               mem_reg_write, mem_mem_read, mem_mem_write, mem_funct3
    );

    modport slave (
        input  ex_valid, ex_alu_result, ex_store_data, ex_pc_plus4, ex_pc_imm,
               ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
               ex_jal, ex_jalr, ex_funct3, mem_ready,
        output ex_ready, mem_valid, mem_wb_data, mem_store_data, mem_rd,
               mem_reg_write, mem_mem_read, mem_mem_write, mem_funct3
    );

endinterface

// File: rtl/ex_mem_stage_pipe_skid_buf.sv
// pipe_skid_buf: generic two-entry valid/ready buffer (head + skid) with flush.
// in_ready is a pure state decode, so there is no path from out_ready to in_ready.
module pipe_skid_buf
    import ex_mem_pkg::*;
#(
    parameter type T = logic [7:0]
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  T           in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output T           out_data,
    output occ_state_t state
);

    occ_state_t state_q, state_d;
    T           head_q, skid_q;
    logic       push, pop;
    logic       load_head_in, load_head_skid, load_skid;

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = head_q;
    assign state     = state_q;

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d      = ONE;
                        load_head_in = 1'b1;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        state_d   = TWO;
                        load_skid = 1'b1;
                    end else if (pop && !push) begin
                        state_d = EMPTY;
                    end else if (push && pop) begin
                        load_head_in = 1'b1;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d        = ONE;
                        load_head_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_head_in) begin
                head_q <= in_data;
            end else if (load_head_skid) begin
                head_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM stage: elastic capture of ALU results, branch/jump redirect, forwarding tap.
// Define EX_MEM_PERF_EN to build the perf_* counters; otherwise they read 0.
module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int DATA_WIDTH     = EM_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = EM_REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    ex_mem_stage_if.slave             bus,
    input  logic                      flush,
    output logic                      redirect_valid,
    output logic [DATA_WIDTH-1:0]     redirect_pc,
    output logic                      fwd_valid,
    output logic [REG_ADDR_WIDTH-1:0] fwd_rd,
    output logic [DATA_WIDTH-1:0]     fwd_data,
    output logic [31:0]               perf_accepted,
    output logic [31:0]               perf_stall,
    output logic [31:0]               perf_redirect,
    output occ_state_t                occ_state
);

    ex_mem_payload_t       in_pl, head_pl;
    logic                  ex_ready, mem_valid, accept, taken, redirect_q;
    logic [DATA_WIDTH-1:0] target, redirect_pc_q;

    // Jumps write the link value; everything else writes the ALU result.
    always_comb begin
        in_pl.wb_data    = (bus.ex_jal | bus.ex_jalr) ? bus.ex_pc_plus4 : bus.ex_alu_result;
        in_pl.store_data = bus.ex_store_data;
        in_pl.rd         = bus.ex_rd;
        in_pl.reg_write  = bus.ex_reg_write;
        in_pl.mem_read   = bus.ex_mem_read;
        in_pl.mem_write  = bus.ex_mem_write;
        in_pl.funct3     = bus.ex_funct3;
    end

    pipe_skid_buf #(.T(ex_mem_payload_t)) u_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (bus.ex_valid),
        .in_ready  (ex_ready),
        .in_data   (in_pl),
        .out_valid (mem_valid),
        .out_ready (bus.mem_ready),
        .out_data  (head_pl),
        .state     (occ_state)
    );

    assign bus.ex_ready       = ex_ready;
    assign bus.mem_valid      = mem_valid;
    assign bus.mem_wb_data    = head_pl.wb_data;
    assign bus.mem_store_data = head_pl.store_data;
    assign bus.mem_rd         = head_pl.rd;
    assign bus.mem_reg_write  = head_pl.reg_write;
    assign bus.mem_mem_read   = head_pl.mem_read;
    assign bus.mem_mem_write  = head_pl.mem_write;
    assign bus.mem_funct3     = head_pl.funct3;

    assign fwd_valid = mem_valid & head_pl.reg_write & (head_pl.rd != '0);
    assign fwd_rd    = head_pl.rd;
    assign fwd_data  = head_pl.wb_data;

    assign accept = bus.ex_valid & ex_ready & ~flush;
    assign taken  = is_taken(bus.ex_branch, bus.ex_jal, bus.ex_jalr, bus.ex_alu_result[0]);
    assign target = bus.ex_jalr ? {bus.ex_alu_result[DATA_WIDTH-1:1], 1'b0} : bus.ex_pc_imm;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            redirect_q <= accept & taken;
            if (accept & taken) begin
                redirect_pc_q <= target;
            end
        end
    end

    // A flush in the issue cycle kills the redirect that was about to go out.
    assign redirect_valid = redirect_q & ~flush;
    assign redirect_pc    = redirect_pc_q;

`ifdef EX_MEM_PERF_EN
    logic [31:0] acc_cnt_q, stall_cnt_q, redir_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_cnt_q   <= '0;
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            if (accept) begin
                acc_cnt_q <= acc_cnt_q + 32'd1;
            end
            if (bus.ex_valid & ~ex_ready) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (redirect_valid) begin
                redir_cnt_q <= redir_cnt_q + 32'd1;
            end
        end
    end

    assign perf_accepted = acc_cnt_q;
    assign perf_stall    = stall_cnt_q;
    assign perf_redirect = redir_cnt_q;
`else
    assign perf_accepted = '0;
    assign perf_stall    = '0;
    assign perf_redirect = '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios plus a randomized run against a
// queue-based reference model of the stage.
module tb_ex_mem_stage;
    import ex_mem_pkg::*;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int PW = $bits(ex_mem_payload_t);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic              redirect_valid;
    logic [DW-1:0]     redirect_pc;
    logic              fwd_valid;
    logic [RW-1:0]     fwd_rd;
    logic [DW-1:0]     fwd_data;
    logic [31:0]       perf_accepted, perf_stall, perf_redirect;
    occ_state_t        occ_state;

    int vectors = 0;
    int errors  = 0;

    // Reference model: in-order queue of expected payloads, pending redirect, counters.
    logic [PW-1:0] exp_q[$];
    logic          m_redir    = 1'b0;
    logic [DW-1:0] m_redir_pc = '0;
    logic [31:0]   m_acc      = '0;
    logic [31:0]   m_stall    = '0;
    logic [31:0]   m_redirs   = '0;

    always #5 clk = ~clk;

    ex_mem_stage_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW)) bus ();

    ex_mem_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fwd_valid      (fwd_valid),
        .fwd_rd         (fwd_rd),
        .fwd_data       (fwd_data),
        .perf_accepted  (perf_accepted),
        .perf_stall     (perf_stall),
        .perf_redirect  (perf_redirect),
        .occ_state      (occ_state)
    );

    function automatic logic [PW-1:0] dut_pl();
        ex_mem_payload_t p;
        p.wb_data    = bus.mem_wb_data;
        p.store_data = bus.mem_store_data;
        p.rd         = bus.mem_rd;
        p.reg_write  = bus.mem_reg_write;
        p.mem_read   = bus.mem_mem_read;
        p.mem_write  = bus.mem_mem_write;
        p.funct3     = bus.mem_funct3;
        return p;
    endfunction

    task automatic m_reset();
        exp_q.delete();
        m_redir  = 1'b0;
        m_acc    = '0;
        m_stall  = '0;
        m_redirs = '0;
    endtask

    // Advance the model with the inputs currently applied, then cross one rising edge.
    task automatic tick();
        bit              acc, pop, tk;
        ex_mem_payload_t p;
        acc = bus.ex_valid && (exp_q.size() < 2) && !flush;
        pop = (exp_q.size() > 0) && bus.mem_ready;
        if (bus.ex_valid && exp_q.size() >= 2) m_stall++;
        if (m_redir && !flush) m_redirs++;
        if (acc) m_acc++;
        tk = bus.ex_jal || bus.ex_jalr || (bus.ex_branch && bus.ex_alu_result[0]);
        p.wb_data    = (bus.ex_jal || bus.ex_jalr) ? bus.ex_pc_plus4 : bus.ex_alu_result;
        p.store_data = bus.ex_store_data;
        p.rd         = bus.ex_rd;
        p.reg_write  = bus.ex_reg_write;
        p.mem_read   = bus.ex_mem_read;
        p.mem_write  = bus.ex_mem_write;
        p.funct3     = bus.ex_funct3;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(p);
        end
        m_redir = acc && tk;
        if (acc && tk) m_redir_pc = bus.ex_jalr ? (bus.ex_alu_result & ~32'h1) : bus.ex_pc_imm;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.ex_valid      = 1'b0;
        bus.ex_branch     = 1'b0;
        bus.ex_jal        = 1'b0;
        bus.ex_jalr       = 1'b0;
        bus.ex_reg_write  = 1'b0;
        bus.ex_mem_read   = 1'b0;
        bus.ex_mem_write  = 1'b0;
        flush             = 1'b0;
    endtask

    task automatic set_ex(input logic [DW-1:0] alu, input logic [DW-1:0] pc4,
                          input logic [DW-1:0] pcimm, input logic [RW-1:0] rd,
                          input logic rw, input logic br, input logic jal, input logic jalr);
        bus.ex_valid      = 1'b1;
        bus.ex_alu_result = alu;
        bus.ex_store_data = $urandom;
        bus.ex_pc_plus4   = pc4;
        bus.ex_pc_imm     = pcimm;
        bus.ex_rd         = rd;
        bus.ex_reg_write  = rw;
        bus.ex_mem_read   = 1'b0;
        bus.ex_mem_write  = 1'b0;
        bus.ex_branch     = br;
        bus.ex_jal        = jal;
        bus.ex_jalr       = jalr;
        bus.ex_funct3     = F3_LW;
    endtask

    task automatic test_reset();
        drive_idle();
        bus.mem_ready     = 1'b1;
        bus.ex_alu_result = '0;
        bus.ex_store_data = '0;
        bus.ex_pc_plus4   = '0;
        bus.ex_pc_imm     = '0;
        bus.ex_rd         = '0;
        bus.ex_funct3     = '0;
        #1 reset = 1'b0;
        #1;
        vectors++;
        if ({bus.mem_valid, bus.ex_ready, redirect_valid, fwd_valid} !== 4'b0100) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=0100", {bus.mem_valid, bus.ex_ready, redirect_valid, fwd_valid});
        end
        vectors++;
        if ({dut_pl(), redirect_pc, fwd_rd, fwd_data} !== '0) begin
            errors++;
            $display("FAIL reset_data got=%h exp=0", {dut_pl(), redirect_pc, fwd_rd, fwd_data});
        end
        vectors++;
        if ({perf_accepted, perf_stall, perf_redirect} !== 96'h0) begin
            errors++;
            $display("FAIL reset_perf got=%h exp=0", {perf_accepted, perf_stall, perf_redirect});
        end
        #1 reset = 1'b1;
        m_reset();
        tick();
    endtask

    task automatic test_alu_fwd();
        bus.mem_ready = 1'b1;
        set_ex(32'h0000_0010, 32'h0, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        tick();
        drive_idle();
        #1;
        vectors++;
        if ({bus.mem_valid, fwd_valid, bus.mem_rd, fwd_rd} !== {1'b1, 1'b1, 5'd5, 5'd5}) begin
            errors++;
            $display("FAIL alu_head_ctrl got=%b exp=%b", {bus.mem_valid, fwd_valid, bus.mem_rd, fwd_rd}, {1'b1, 1'b1, 5'd5, 5'd5});
        end
        vectors++;
        if ({bus.mem_wb_data, fwd_data} !== {32'h10, 32'h10}) begin
            errors++;
            $display("FAIL alu_head_data got=%h exp=%h", {bus.mem_wb_data, fwd_data}, {32'h10, 32'h10});
        end
        tick();
        vectors++;
        if ({bus.mem_valid, fwd_valid, redirect_valid} !== 3'b000) begin
            errors++;
            $display("FAIL alu_drained got=%b exp=000", {bus.mem_valid, fwd_valid, redirect_valid});
        end
    endtask

    task automatic test_branch();
        bus.mem_ready = 1'b1;
        set_ex(32'h1, 32'h8, 32'h40, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        tick();
        drive_idle();
        #1;
        vectors++;
        if ({redirect_valid, redirect_pc} !== {1'b1, 32'h40}) begin
            errors++;
            $display("FAIL br_taken got=%h exp=%h", {redirect_valid, redirect_pc}, {1'b1, 32'h40});
        end
        vectors++;
        if (fwd_valid !== 1'b0) begin
            errors++;
            $display("FAIL br_no_fwd got=%b exp=0", fwd_valid);
        end
        tick();
        vectors++;
        if (redirect_valid !== 1'b0) begin
            errors++;
            $display("FAIL br_one_cycle got=%b exp=0", redirect_valid);
        end
        set_ex(32'h0, 32'h8, 32'h40, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        tick();
        drive_idle();
        #1;
        vectors++;
        if ({redirect_valid, bus.mem_valid} !== 2'b01) begin
            errors++;
            $display("FAIL br_not_taken got=%b exp=01", {redirect_valid, bus.mem_valid});
        end
        tick();
    endtask

    task automatic test_jalr();
        bus.mem_ready = 1'b1;
        set_ex(32'h0000_0103, 32'h24, 32'h999, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        tick();
        drive_idle();
        #1;
        vectors++;
        if ({redirect_valid, redirect_pc} !== {1'b1, 32'h102}) begin
            errors++;
            $display("FAIL jalr_target got=%h exp=%h", {redirect_valid, redirect_pc}, {1'b1, 32'h102});
        end
        vectors++;
        if ({bus.mem_wb_data, fwd_valid} !== {32'h24, 1'b1}) begin
            errors++;
            $display("FAIL jalr_link got=%h exp=%h", {bus.mem_wb_data, fwd_valid}, {32'h24, 1'b1});
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] va, vb, vc;
        logic [DW-1:0] got_q[$];
        va = $urandom; vb = $urandom; vc = $urandom;
        drive_idle();
        reset = 1'b0;
        #1 reset = 1'b1;
        m_reset();
        tick();
        bus.mem_ready = 1'b0;
        set_ex(va, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        tick();
        set_ex(vb, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        vectors++;
        if (bus.ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_second_ready got=%b exp=1", bus.ex_ready);
        end
        tick();
        set_ex(vc, 32'h0, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++;
            if ({bus.ex_ready, bus.mem_valid, bus.mem_wb_data} !== {1'b0, 1'b1, va}) begin
                errors++;
                $display("FAIL bp_held cyc=%0d got=%h exp=%h", i, {bus.ex_ready, bus.mem_valid, bus.mem_wb_data}, {1'b0, 1'b1, va});
            end
            tick();
        end
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bit c_acc;
            #1;
            if (bus.mem_valid === 1'b1) got_q.push_back(bus.mem_wb_data);
            c_acc = bus.ex_valid && (exp_q.size() < 2);
            tick();
            if (c_acc) bus.ex_valid = 1'b0;
        end
        vectors++;
        if (got_q.size() != 3) begin
            errors++;
            $display("FAIL bp_count got=%0d exp=3", got_q.size());
        end else begin
            vectors++;
            if ({got_q[0], got_q[1], got_q[2]} !== {va, vb, vc}) begin
                errors++;
                $display("FAIL bp_order got=%h exp=%h", {got_q[0], got_q[1], got_q[2]}, {va, vb, vc});
            end
        end
        vectors++;
`ifdef EX_MEM_PERF_EN
        if ({perf_accepted, perf_stall, perf_redirect} !== {32'd3, 32'd3, 32'd0}) begin
            errors++;
            $display("FAIL bp_perf got=%0d/%0d/%0d exp=3/3/0", perf_accepted, perf_stall, perf_redirect);
        end
`else
        if ({perf_accepted, perf_stall, perf_redirect} !== 96'h0) begin
            errors++;
            $display("FAIL bp_perf got=%0d/%0d/%0d exp=0/0/0", perf_accepted, perf_stall, perf_redirect);
        end
`endif
    endtask

    task automatic test_flush();
        drive_idle();
        bus.mem_ready = 1'b0;
        set_ex($urandom, 32'h0, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        tick();
        set_ex(32'h1, 32'h0, 32'h80, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        tick();
        bus.ex_valid = 1'b0;
        flush = 1'b1;
        #1;
        vectors++;
        if ({bus.mem_valid, bus.ex_ready, redirect_valid} !== 3'b100) begin
            errors++;
            $display("FAIL flush_two_suppress got=%b exp=100", {bus.mem_valid, bus.ex_ready, redirect_valid});
        end
        tick();
        flush = 1'b0;
        #1;
        vectors++;
        if ({bus.mem_valid, bus.ex_ready, redirect_valid} !== 3'b010) begin
            errors++;
            $display("FAIL flush_empty got=%b exp=010", {bus.mem_valid, bus.ex_ready, redirect_valid});
        end
        set_ex(32'h0, 32'h4, 32'hC0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        tick();
        drive_idle();
        #1;
        vectors++;
        if ({bus.mem_valid, redirect_valid} !== 2'b00) begin
            errors++;
            $display("FAIL flush_same_cycle got=%b exp=00", {bus.mem_valid, redirect_valid});
        end
        vectors++;
`ifdef EX_MEM_PERF_EN
        if (perf_redirect !== m_redirs) begin
`else
        if (perf_redirect !== 32'd0) begin
`endif
            errors++;
            $display("FAIL flush_perf_redirect got=%0d exp=%0d", perf_redirect, m_redirs);
        end
        bus.mem_ready = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        drive_idle();
        bus.mem_ready = 1'b0;
        set_ex(32'h0, 32'h30, 32'h200, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        tick();
        drive_idle();
        #1;
        vectors++;
        if ({bus.mem_valid, redirect_valid} !== 2'b11) begin
            errors++;
            $display("FAIL arst_pre got=%b exp=11", {bus.mem_valid, redirect_valid});
        end
        reset = 1'b0;
        #1;
        vectors++;
        if ({bus.mem_valid, bus.ex_ready, redirect_valid, fwd_valid} !== 4'b0100) begin
            errors++;
            $display("FAIL arst_immediate got=%b exp=0100", {bus.mem_valid, bus.ex_ready, redirect_valid, fwd_valid});
        end
        vectors++;
        if ({perf_accepted, perf_stall, perf_redirect} !== 96'h0) begin
            errors++;
            $display("FAIL arst_perf got=%h exp=0", {perf_accepted, perf_stall, perf_redirect});
        end
        #1 reset = 1'b1;
        m_reset();
        bus.mem_ready = 1'b1;
        tick();
        vectors++;
        if ({bus.mem_valid, redirect_valid} !== 2'b00) begin
            errors++;
            $display("FAIL arst_post got=%b exp=00", {bus.mem_valid, redirect_valid});
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            int              k;
            ex_mem_payload_t h;
            logic            e_fwd;
            k = $urandom_range(0, 5);
            bus.ex_valid      = ($urandom_range(0, 9) < 7);
            bus.ex_alu_result = (k == 3) ? DW'($urandom_range(0, 1)) : DW'($urandom);
            bus.ex_store_data = $urandom;
            bus.ex_pc_plus4   = $urandom;
            bus.ex_pc_imm     = $urandom;
            bus.ex_rd         = ($urandom_range(0, 7) == 0) ? 5'd0 : RW'($urandom_range(1, 31));
            bus.ex_reg_write  = (k == 0) || (k == 1) || (k >= 4);
            bus.ex_mem_read   = (k == 1);
            bus.ex_mem_write  = (k == 2);
            bus.ex_branch     = (k == 3);
            bus.ex_jal        = (k == 4);
            bus.ex_jalr       = (k == 5);
            bus.ex_funct3     = 3'($urandom_range(0, 7));
            bus.mem_ready     = ($urandom_range(0, 9) < 6);
            flush             = ($urandom_range(0, 31) == 0);
            #1;
            vectors++;
            if ({bus.ex_ready, bus.mem_valid} !== {exp_q.size() < 2, exp_q.size() > 0}) begin
                errors++;
                $display("FAIL rnd_occ cyc=%0d got=%b exp=%b", cyc, {bus.ex_ready, bus.mem_valid}, {exp_q.size() < 2, exp_q.size() > 0});
            end
            if (exp_q.size() > 0) begin
                h = exp_q[0];
                vectors++;
                if (dut_pl() !== exp_q[0]) begin
                    errors++;
                    $display("FAIL rnd_payload cyc=%0d got=%h exp=%h", cyc, dut_pl(), exp_q[0]);
                end
                e_fwd = h.reg_write && (h.rd != 5'd0);
            end else begin
                h = '0;
                e_fwd = 1'b0;
            end
            vectors++;
            if (fwd_valid !== e_fwd || (e_fwd && {fwd_rd, fwd_data} !== {h.rd, h.wb_data})) begin
                errors++;
                $display("FAIL rnd_fwd cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", cyc, fwd_valid, fwd_rd, fwd_data, e_fwd, h.rd, h.wb_data);
            end
            vectors++;
            if (redirect_valid !== (m_redir && !flush) || (redirect_valid && redirect_pc !== m_redir_pc)) begin
                errors++;
                $display("FAIL rnd_redirect cyc=%0d got=%b/%h exp=%b/%h", cyc, redirect_valid, redirect_pc, m_redir && !flush, m_redir_pc);
            end
            vectors++;
`ifdef EX_MEM_PERF_EN
            if ({perf_accepted, perf_stall, perf_redirect} !== {m_acc, m_stall, m_redirs}) begin
`else
            if ({perf_accepted, perf_stall, perf_redirect} !== 96'h0) begin
`endif
                errors++;
                $display("FAIL rnd_perf cyc=%0d got=%0d/%0d/%0d model=%0d/%0d/%0d", cyc, perf_accepted, perf_stall, perf_redirect, m_acc, m_stall, m_redirs);
            end
            tick();
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_alu_fwd();
        test_branch();
        test_jalr();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
